// File: rtl/inert_pkg.sv
// Shared types and helpers for the inertial-sensor front end.
// Holds the front-end state enum, the SPI read-word constants and
// a helper that builds a read command from a register address.
package inert_pkg;

    typedef enum logic [2:0] {
        INIT,
        INIT_WT,
        IDLE,
        RD_LO,
        RD_HI,
        COMMIT
    } inert_state_t;

    localparam logic       RD_BIT     = 1'b1;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

    // Read word: read flag, 7-bit register address, dummy byte clocked out
    // while the sensor returns the register contents.
    function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
        return {RD_BIT, addr, DUMMY_BYTE};
    endfunction

endpackage

// File: rtl/SPI_mnrch.sv
// 16-bit SPI master, mode 3 (SCLK idles high, MOSI changes on the falling
// edge, MISO sampled on the rising edge). SCLK runs at clk/4.
// A one-cycle wrt starts a transfer of cmd; done pulses for one cycle once
// all 16 bits are exchanged, with rd_data holding the received word.
// Handshake: wrt is only honoured while idle; done marks the last cycle
// with SS_n low, so the earliest next wrt lands one cycle after done.
module SPI_mnrch (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] rd_data
);

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_SHIFT,
        SPI_BACK
    } spi_state_t;

    spi_state_t  state_q, state_d;
    logic [1:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shft_q, shft_d;
    logic        miso_q, miso_d;

    // State and shift register; a reset mid-transfer drops straight to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SPI_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shft_q  <= '0;
            miso_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shft_q  <= shft_d;
            miso_q  <= miso_d;
        end
    end

    // Bit sequencing: sample MISO as SCLK rises, shift as SCLK falls.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shft_d  = shft_q;
        miso_d  = miso_q;
        case (state_q)
            SPI_IDLE: begin
                if (wrt) begin
                    shft_d  = cmd;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SPI_SHIFT;
                end
            end
            SPI_SHIFT: begin
                div_d = div_q + 2'd1;
                if (div_q == 2'd1) begin
                    miso_d = MISO;
                end
                if (div_q == 2'd3) begin
                    shft_d = {shft_q[14:0], miso_q};
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        state_d = SPI_BACK;
                    end
                end
            end
            SPI_BACK: begin
                state_d = SPI_IDLE;
            end
            default: begin
                state_d = SPI_IDLE;
            end
        endcase
    end

    assign SS_n    = (state_q == SPI_IDLE);
    assign SCLK    = (state_q != SPI_SHIFT) | div_q[1];
    assign MOSI    = (state_q == SPI_SHIFT) & shft_q[15];
    assign done    = (state_q == SPI_BACK);
    assign rd_data = shft_q;

endmodule

// File: rtl/inert_multi_rd.sv
// Inertial-sensor front end: one configuration write after reset, then on
// each data-ready interrupt reads NUM_CH signed 16-bit channels (low byte,
// then high byte) and commits the whole frame to ch_data at once.
// Optional feature macro: INERT_AVG_EN enables a 1/4-weight smoothing
// filter on commit (first frame after reset seeds the filter directly).
// dbg_state exposes the sequencer state for board debug and checkers.
module inert_multi_rd
    import inert_pkg::*;
#(
    parameter int          NUM_CH    = 3,
    parameter logic [6:0]  BASE_ADDR = 7'h22,
    parameter logic [15:0] INIT_CMD  = 16'h0D02
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  INT,
    input  logic                  NEXT,
    input  logic                  MISO,
    output logic                  SS_n,
    output logic                  SCLK,
    output logic                  MOSI,
    output logic [16*NUM_CH-1:0]  ch_data,
    output logic                  vld,
    output logic                  ovr,
    output logic [7:0]            LED,
    output inert_state_t          dbg_state
);

    localparam int            CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

    inert_state_t  state_q, state_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [CW-1:0] sel_q;
    logic          pend_q, pend_d;
    logic          ovr_q, ovr_d;
    logic [2:0]    int_sync_q, next_sync_q;
    logic [7:0]    lo_q;
    logic [15:0]   shadow_q [NUM_CH];
    logic [15:0]   bank_q   [NUM_CH];

    logic          wrt, done;
    logic [15:0]   cmd, rd_data;
    logic          int_rise, next_rise;
    logic          pend_clr, lo_load, hi_load, commit;
    logic [6:0]    lo_addr;
    logic          unused_rd_hi;

    SPI_mnrch u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .cmd     (cmd),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .done    (done),
        .rd_data (rd_data)
    );

    // Two-flop synchronisers plus one history flop for rising-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_sync_q  <= '0;
            next_sync_q <= '0;
        end else begin
            int_sync_q  <= {int_sync_q[1:0], INT};
            next_sync_q <= {next_sync_q[1:0], NEXT};
        end
    end

    assign int_rise  = int_sync_q[1]  & ~int_sync_q[2];
    assign next_rise = next_sync_q[1] & ~next_sync_q[2];
    assign lo_addr   = BASE_ADDR + 7'({ch_q, 1'b0});

    // Sequencer register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            busy_q  <= 1'b0;
            ch_q    <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic; each SPI state issues one wrt, then waits for done.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        ch_d     = ch_q;
        wrt      = 1'b0;
        cmd      = INIT_CMD;
        pend_clr = 1'b0;
        lo_load  = 1'b0;
        hi_load  = 1'b0;
        commit   = 1'b0;
        case (state_q)
            INIT: begin
                wrt     = 1'b1;
                state_d = INIT_WT;
            end
            INIT_WT: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (pend_q) begin
                    pend_clr = 1'b1;
                    ch_d     = '0;
                    busy_d   = 1'b0;
                    state_d  = RD_LO;
                end
            end
            RD_LO: begin
                cmd = rd_cmd(lo_addr);
                if (!busy_q) begin
                    wrt    = 1'b1;
                    busy_d = 1'b1;
                end else if (done) begin
                    lo_load = 1'b1;
                    busy_d  = 1'b0;
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                cmd = rd_cmd(lo_addr + 7'd1);
                if (!busy_q) begin
                    wrt    = 1'b1;
                    busy_d = 1'b1;
                end else if (done) begin
                    hi_load = 1'b1;
                    busy_d  = 1'b0;
                    if (ch_q == LAST_CH) begin
                        state_d = COMMIT;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = RD_LO;
                    end
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Pending-frame flag: a new edge wins over a same-cycle clear; an edge
    // arriving while a frame is already pending is dropped and flagged.
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (pend_clr) begin
            pend_d = 1'b0;
        end
        if (int_rise && (state_q != INIT) && (state_q != INIT_WT)) begin
            if (pend_q && !pend_clr) begin
                ovr_d = 1'b1;
            end
            pend_d = 1'b1;
        end
    end

`ifdef INERT_AVG_EN
    logic seeded_q;

    // One smoothing step: old + (new - old) / 4, difference kept in 17 bits.
    function automatic logic [15:0] avg_step(input logic [15:0] old_v,
                                             input logic [15:0] new_v);
        logic signed [16:0] diff;
        diff = $signed({new_v[15], new_v}) - $signed({old_v[15], old_v});
        return old_v + 16'(diff >>> 2);
    endfunction

    // Tracks whether the filter has been seeded since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seeded_q <= 1'b0;
        end else if (commit) begin
            seeded_q <= 1'b1;
        end
    end
`endif

    // Frame datapath: byte capture, shadow bank, committed bank, LED select.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q  <= '0;
            sel_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= '0;
                bank_q[k]   <= '0;
            end
        end else begin
            if (lo_load) begin
                lo_q <= rd_data[7:0];
            end
            if (hi_load) begin
                shadow_q[ch_q] <= {rd_data[7:0], lo_q};
            end
            if (commit) begin
                for (int k = 0; k < NUM_CH; k++) begin
`ifdef INERT_AVG_EN
                    bank_q[k] <= seeded_q ? avg_step(bank_q[k], shadow_q[k])
                                          : shadow_q[k];
`else
                    bank_q[k] <= shadow_q[k];
`endif
                end
            end
            if (next_rise) begin
                sel_q <= (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign ch_data[16*k +: 16] = bank_q[k];
    end

    assign unused_rd_hi = ^rd_data[15:8];
    assign vld          = commit;
    assign ovr          = ovr_q;
    assign LED          = bank_q[sel_q][15:8];
    assign dbg_state    = state_q;

endmodule
